stack_pointer: RTL and testbench



---
 rtl/stack_pointer_pkg.sv | 20 ++
 rtl/stack_pointer.sv | 91 +++++++++
 tb/tb_stack_pointer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/stack_pointer_pkg.sv
// Shared CPU stack definitions: pointer width, default stack window and the
// request decode used by the stack pointer and the control unit.
package stack_pointer_pkg;

    localparam int          SP_WIDTH         = 16;
    localparam logic [15:0] SP_BASE_DEFAULT  = 16'h0000;
    localparam logic [15:0] SP_LIMIT_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        SP_OP_NONE = 2'b00,
        SP_OP_POP  = 2'b01,
        SP_OP_PUSH = 2'b10,
        SP_OP_BOTH = 2'b11
    } sp_op_e;

    function automatic sp_op_e sp_decode_op(input logic push, input logic pop);
        return sp_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/stack_pointer.sv
// CPU stack pointer: steps up on push and down on pop inside [SP_BASE, SP_LIMIT],
// with empty/full decodes and sticky overflow/underflow error flags.
module stack_pointer
    import stack_pointer_pkg::*;
#(
    parameter int               WIDTH    = SP_WIDTH,
    parameter logic [WIDTH-1:0] SP_BASE  = SP_BASE_DEFAULT,
    parameter logic [WIDTH-1:0] SP_LIMIT = SP_LIMIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] SP_STEP = WIDTH'(1);

    logic [WIDTH-1:0] sp_r;
    logic [WIDTH-1:0] sp_next_s;
    logic             overflow_r;
    logic             overflow_next_s;
    logic             underflow_r;
    logic             underflow_next_s;
    logic             at_base_s;
    logic             at_limit_s;
    sp_op_e           op_s;

    assign at_base_s  = (sp_r == SP_BASE);
    assign at_limit_s = (sp_r == SP_LIMIT);
    assign op_s       = sp_decode_op(push, pop);

    // Next pointer and flag values; bounds are saturating, never wrapping.
    always_comb begin
        sp_next_s        = sp_r;
        overflow_next_s  = overflow_r;
        underflow_next_s = underflow_r;
        if (reset) begin
            sp_next_s        = SP_BASE;
            overflow_next_s  = 1'b0;
            underflow_next_s = 1'b0;
        end else begin
            case (op_s)
                SP_OP_PUSH: begin
                    if (!at_limit_s) begin
                        sp_next_s = sp_r + SP_STEP;
                    end else begin
                        overflow_next_s = 1'b1;
                    end
                end
                SP_OP_POP: begin
                    if (!at_base_s) begin
                        sp_next_s = sp_r - SP_STEP;
                    end else begin
                        underflow_next_s = 1'b1;
                    end
                end
                SP_OP_NONE, SP_OP_BOTH: begin
                    sp_next_s = sp_r;
                end
                default: begin
                    sp_next_s = sp_r;
                end
            endcase
        end
    end

    // State register for the pointer and the sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_r        <= SP_BASE;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            sp_r        <= sp_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

    assign out       = sp_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign empty     = at_base_s;
    assign full      = at_limit_s;

endmodule

// File: tb/tb_stack_pointer.sv
// Directed bench for stack_pointer: default window on one instance, a
// three-entry window (FFFD..FFFF) on a second for the overflow boundary.
module tb_stack_pointer;

    logic        clk = 1'b0;
    logic        reset_a = 1'b0, push_a = 1'b0, pop_a = 1'b0;
    logic        reset_b = 1'b0, push_b = 1'b0, pop_b = 1'b0;
    logic [15:0] out_a, out_b;
    logic        empty_a, full_a, ovf_a, unf_a;
    logic        empty_b, full_b, ovf_b, unf_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stack_pointer u_dut_a (
        .clk(clk), .reset(reset_a), .push(push_a), .pop(pop_a),
        .out(out_a), .empty(empty_a), .full(full_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    stack_pointer #(.WIDTH(16), .SP_BASE(16'hFFFD), .SP_LIMIT(16'hFFFF)) u_dut_b (
        .clk(clk), .reset(reset_b), .push(push_b), .pop(pop_b),
        .out(out_b), .empty(empty_b), .full(full_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check pointer plus the four status bits {empty, full, overflow, underflow}.
    task automatic check_a(input string tag, input logic [15:0] exp_out, input logic [3:0] exp_st);
        check({tag, ".out"}, out_a, exp_out);
        check({tag, ".st"}, {12'h000, empty_a, full_a, ovf_a, unf_a}, {12'h000, exp_st});
    endtask

    task automatic check_b(input string tag, input logic [15:0] exp_out, input logic [3:0] exp_st);
        check({tag, ".out"}, out_b, exp_out);
        check({tag, ".st"}, {12'h000, empty_b, full_b, ovf_b, unf_b}, {12'h000, exp_st});
    endtask

    task automatic step_a(input logic r, input logic pu, input logic po);
        reset_a = r; push_a = pu; pop_a = po;
        @(posedge clk); #1;
        reset_a = 1'b0; push_a = 1'b0; pop_a = 1'b0;
    endtask

    task automatic step_b(input logic r, input logic pu, input logic po);
        reset_b = r; push_b = pu; pop_b = po;
        @(posedge clk); #1;
        reset_b = 1'b0; push_b = 1'b0; pop_b = 1'b0;
    endtask

    initial begin
        // Instance A: default window 0000..FFFF. Status = {empty, full, ovf, unf}.
        step_a(1'b1, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b0);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("a_pre", 16'h0002, 4'b0000);
        step_a(1'b1, 1'b1, 1'b0);
        check_a("a_reset", 16'h0000, 4'b1000);

        step_a(1'b0, 1'b1, 1'b0);
        check_a("a_push1", 16'h0001, 4'b0000);
        step_a(1'b0, 1'b0, 1'b1);
        check_a("a_pop1", 16'h0000, 4'b1000);

        step_a(1'b0, 1'b1, 1'b0);
        check_a("a_held_p", 16'h0001, 4'b0000);
        step_a(1'b0, 1'b0, 1'b0);
        check_a("a_idle", 16'h0001, 4'b0000);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("a_held2", 16'h0002, 4'b0000);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("a_held3", 16'h0003, 4'b0000);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("a_held4", 16'h0004, 4'b0000);
        step_a(1'b0, 1'b0, 1'b1);
        check_a("a_pop3", 16'h0003, 4'b0000);

        step_a(1'b0, 1'b1, 1'b1);
        check_a("a_both1", 16'h0003, 4'b0000);
        step_a(1'b0, 1'b1, 1'b1);
        check_a("a_both2", 16'h0003, 4'b0000);

        step_a(1'b0, 1'b0, 1'b1);
        step_a(1'b0, 1'b0, 1'b1);
        step_a(1'b0, 1'b0, 1'b1);
        check_a("a_drain", 16'h0000, 4'b1000);
        step_a(1'b0, 1'b0, 1'b1);
        check_a("a_unf", 16'h0000, 4'b1001);
        step_a(1'b0, 1'b1, 1'b1);
        check_a("a_unf_both", 16'h0000, 4'b1001);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("a_unf_p1", 16'h0001, 4'b0001);
        step_a(1'b0, 1'b1, 1'b0);
        check_a("a_unf_p2", 16'h0002, 4'b0001);
        step_a(1'b1, 1'b0, 1'b1);
        check_a("a_unf_clr", 16'h0000, 4'b1000);

        // Instance B: window FFFD..FFFF for the full/overflow boundary.
        step_b(1'b1, 1'b0, 1'b0);
        check_b("b_reset", 16'hFFFD, 4'b1000);
        step_b(1'b0, 1'b1, 1'b0);
        check_b("b_push1", 16'hFFFE, 4'b0000);
        step_b(1'b0, 1'b1, 1'b0);
        check_b("b_full", 16'hFFFF, 4'b0100);
        step_b(1'b0, 1'b1, 1'b0);
        check_b("b_ovf", 16'hFFFF, 4'b0110);
        step_b(1'b0, 1'b0, 1'b0);
        check_b("b_ovf_idle", 16'hFFFF, 4'b0110);
        step_b(1'b0, 1'b0, 1'b1);
        check_b("b_pop", 16'hFFFE, 4'b0010);
        step_b(1'b0, 1'b1, 1'b0);
        check_b("b_repush", 16'hFFFF, 4'b0110);
        step_b(1'b1, 1'b1, 1'b0);
        check_b("b_rst_push", 16'hFFFD, 4'b1000);
        step_b(1'b0, 1'b0, 1'b1);
        check_b("b_unf", 16'hFFFD, 4'b1001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
